prg_uploader: RTL and testbench

- Reverse path of the PRG download flow: reads the BASIC program currently in RAM and streams it byte by byte to the io-controller side, for saving as a *.prg file.
- Reads the 16-bit PROGND pointer from RAM, derives the program length, then reads PRG_START_ADDR..PROGND-1 and presents each byte on a valid/ready stream.
- Holds the CPU off through `uploading`, with the same two-cycle settle tail used by the download path.

---
 rtl/prg_uploader.sv | 143 ++++++++++++++
 tb/tb_prg_uploader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prg_uploader.sv
// Reads the BASIC program image out of RAM (bounded by the PROGND pointer) and
// streams it byte by byte over a valid/ready interface, holding the CPU off meanwhile.
module prg_uploader #(
    parameter logic [24:0] PRG_START_ADDR = 25'h008241,
    parameter logic [24:0] PTR_PROGND     = 25'h008225,
    parameter logic [15:0] MAX_LEN        = 16'hC000,
    parameter int          READ_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        rd,
    output logic [24:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        uploading,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, CHECK, RD_BYTE, SEND, SETTLE1, SETTLE2
    } state_t;

    localparam logic [15:0] START_LO = PRG_START_ADDR[15:0];
    localparam logic [1:0]  LAT      = 2'(READ_LATENCY);

    state_t      state;
    logic [1:0]  lat_cnt;
    logic [15:0] ptr;
    logic [15:0] len;
    logic [15:0] offset;
    logic [15:0] len_calc;
    logic [15:0] next_off;
    logic        lat_hit;

    assign len_calc = ptr - START_LO;
    assign next_off = offset + 16'd1;
    // lat_cnt restarts at 0 with every rd; data is valid once it reaches LAT
    assign lat_hit  = (lat_cnt == LAT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_cnt   <= 2'd0;
            ptr       <= 16'd0;
            len       <= 16'd0;
            offset    <= 16'd0;
            rd        <= 1'b0;
            addr      <= 25'd0;
            out_data  <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            uploading <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            rd   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        uploading <= 1'b1;
                        error     <= 1'b0;
                        rd        <= 1'b1;
                        addr      <= PTR_PROGND;
                        lat_cnt   <= 2'd0;
                        state     <= RD_LO;
                    end
                end
                RD_LO: begin
                    if (lat_hit) begin
                        ptr[7:0] <= din;
                        rd       <= 1'b1;
                        addr     <= PTR_PROGND + 25'd1;
                        lat_cnt  <= 2'd0;
                        state    <= RD_HI;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                RD_HI: begin
                    if (lat_hit) begin
                        ptr[15:8] <= din;
                        state     <= CHECK;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                CHECK: begin
                    // Empty, backwards or oversized program: report and skip the stream
                    if (ptr <= START_LO || len_calc > MAX_LEN) begin
                        error <= 1'b1;
                        state <= SETTLE1;
                    end else begin
                        len     <= len_calc;
                        offset  <= 16'd0;
                        rd      <= 1'b1;
                        addr    <= PRG_START_ADDR;
                        lat_cnt <= 2'd0;
                        state   <= RD_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (lat_hit) begin
                        out_data  <= din;
                        out_valid <= 1'b1;
                        out_last  <= (offset == len - 16'd1);
                        state     <= SEND;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= SETTLE1;
                        end else begin
                            offset  <= next_off;
                            rd      <= 1'b1;
                            addr    <= PRG_START_ADDR + {9'd0, next_off};
                            lat_cnt <= 2'd0;
                            state   <= RD_BYTE;
                        end
                    end
                end
                SETTLE1: state <= SETTLE2;
                SETTLE2: begin
                    uploading <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_uploader.sv
// Directed bench for prg_uploader: one instance at READ_LATENCY=1, one at 3,
// both fed from the same RAM image with a strict-latency read model.
module tb_prg_uploader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, start3, out_ready;
    logic        rd, rd3;
    logic [24:0] addr, addr3;
    logic [7:0]  din, din3, out_data, out_data3;
    logic        out_valid, out_valid3, out_last, out_last3;
    logic        uploading, uploading3, done, done3, error, error3;

    prg_uploader #(.READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rd(rd), .addr(addr), .din(din),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .uploading(uploading), .done(done), .error(error)
    );

    prg_uploader #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .rd(rd3), .addr(addr3), .din(din3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(1'b1), .out_last(out_last3),
        .uploading(uploading3), .done(done3), .error(error3)
    );

    // RAM model: data is valid only exactly READ_LATENCY cycles after rd, 8'hEE otherwise
    logic [7:0] mem [0:65535];
    logic [7:0] p1;
    logic [7:0] p3 [0:2];
    always @(posedge clk) begin
        p1    <= rd  ? mem[addr[15:0]]  : 8'hEE;
        p3[0] <= rd3 ? mem[addr3[15:0]] : 8'hEE;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign din  = p1;
    assign din3 = p3[2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor
    logic [24:0] rd_q[$];
    logic [24:0] rd3_q[$];
    logic [7:0]  beat_q[$];
    logic [7:0]  beat3_q[$];
    bit          last_q[$];
    bit          last3_q[$];
    int          done_cnt, rd_while_valid, unstable, last_wo_valid, upl_cycles;
    bit          prev_stall;
    logic [7:0]  prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (rd) rd_q.push_back(addr);
        if (rd && out_valid) rd_while_valid++;
        if (out_last && !out_valid) last_wo_valid++;
        if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            unstable++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_valid && out_ready) begin
            beat_q.push_back(out_data);
            last_q.push_back(out_last);
        end
        if (done) done_cnt++;
        if (uploading) upl_cycles++;
        if (rd3) rd3_q.push_back(addr3);
        if (out_valid3) begin
            beat3_q.push_back(out_data3);
            last3_q.push_back(out_last3);
        end
    end

    // out_ready driver: either tied high, or held low for 5 cycles of every beat
    bit bp_mode = 1'b0;
    int stall = 0;
    always @(posedge clk) begin
        #1;
        if (!bp_mode) out_ready = 1'b1;
        else if (out_valid) begin
            if (stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else out_ready = 1'b1;
        end else begin
            out_ready = 1'b0;
            stall = 0;
        end
    end

    task automatic clear_mon();
        rd_q.delete(); rd3_q.delete(); beat_q.delete(); beat3_q.delete();
        last_q.delete(); last3_q.delete();
        done_cnt = 0; rd_while_valid = 0; unstable = 0; last_wo_valid = 0; upl_cycles = 0;
    endtask

    task automatic set_ptr(input logic [15:0] p);
        mem[16'h8225] = p[7:0];
        mem[16'h8226] = p[15:8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_basic_stream(input string tag);
        logic [7:0] exp_b [3];
        exp_b = '{8'h0A, 8'h0B, 8'h0C};
        check({tag, "_beats"}, beat_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_data"}, (i < beat_q.size()) ? {24'd0, beat_q[i]} : 32'hDEAD, {24'd0, exp_b[i]});
            check({tag, "_last"}, (i < last_q.size()) ? {31'd0, last_q[i]} : 32'hDEAD, (i == 2) ? 1 : 0);
        end
    endtask

    task automatic check_rd_addrs(input string tag);
        logic [24:0] exp_a [5];
        exp_a = '{25'h8225, 25'h8226, 25'h8241, 25'h8242, 25'h8243};
        check({tag, "_rd_count"}, rd_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check({tag, "_rd_addr"}, (i < rd_q.size()) ? {7'd0, rd_q[i]} : 32'hDEAD, {7'd0, exp_a[i]});
    endtask

    bit seen;
    int n;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h8241] = 8'h0A;
        mem[16'h8242] = 8'h0B;
        mem[16'h8243] = 8'h0C;
        set_ptr(16'h8244);
        reset_n = 1'b0; start = 1'b0; start3 = 1'b0;
        tick(); tick();
        check("rst_rd", rd, 0);
        check("rst_addr", addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_uploading", uploading, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset_n = 1'b1;
        tick();

        // Basic upload on both latencies
        clear_mon();
        start = 1'b1; start3 = 1'b1;
        tick();
        start = 1'b0; start3 = 1'b0;
        check("basic_upl_after_start", uploading, 1);
        check("basic_first_rd", rd, 1);
        check("basic_first_addr", addr, 25'h8225);
        wait_done(200, seen);
        check("basic_done_seen", seen, 1);
        check("basic_error", error, 0);
        check("basic_upl_at_done", uploading, 0);
        tick();
        check("basic_done_pulse", done, 0);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_upl_cycles", upl_cycles, 16);
        check_basic_stream("basic");
        check_rd_addrs("basic");
        check("basic_last_wo_valid", last_wo_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done3) seen = 1'b1;
            else tick();
        end
        check("lat3_done_seen", seen, 1);
        check("lat3_error", error3, 0);
        check("lat3_beats", beat3_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("lat3_data", (i < beat3_q.size()) ? {24'd0, beat3_q[i]} : 32'hDEAD, 32'h0A + i);
        check("lat3_last", (last3_q.size() == 3) ? {29'd0, last3_q[0], last3_q[1], last3_q[2]} : 32'hDEAD, 1);
        check("lat3_rd_count", rd3_q.size(), 5);
        check("lat3_rd_addr4", (rd3_q.size() == 5) ? {7'd0, rd3_q[4]} : 32'hDEAD, 25'h8243);
        tick();

        // Backpressure
        bp_mode = 1'b1;
        tick();
        clear_mon();
        pulse_start();
        wait_done(300, seen);
        check("bp_done_seen", seen, 1);
        check_basic_stream("bp");
        check_rd_addrs("bp");
        check("bp_unstable", unstable, 0);
        check("bp_rd_while_valid", rd_while_valid, 0);
        bp_mode = 1'b0;
        tick();

        // Empty and invalid pointers
        set_ptr(16'h8241);
        clear_mon();
        pulse_start();
        wait_done(50, seen);
        check("empty_done_seen", seen, 1);
        check("empty_error", error, 1);
        check("empty_beats", beat_q.size(), 0);
        check("empty_upl_at_done", uploading, 0);
        tick();
        set_ptr(16'h8000);
        clear_mon();
        pulse_start();
        check("neg_error_cleared", error, 0);
        wait_done(50, seen);
        check("neg_done_seen", seen, 1);
        check("neg_error", error, 1);
        check("neg_beats", beat_q.size(), 0);
        check("neg_rd_count", rd_q.size(), 2);
        tick();

        // Oversize, then single-byte program
        set_ptr(16'h4242);
        clear_mon();
        pulse_start();
        wait_done(50, seen);
        check("over_done_seen", seen, 1);
        check("over_error", error, 1);
        check("over_beats", beat_q.size(), 0);
        tick();
        set_ptr(16'h8242);
        clear_mon();
        pulse_start();
        check("one_error_cleared", error, 0);
        wait_done(50, seen);
        check("one_done_seen", seen, 1);
        check("one_error", error, 0);
        check("one_beats", beat_q.size(), 1);
        check("one_data", (beat_q.size() > 0) ? {24'd0, beat_q[0]} : 32'hDEAD, 32'h0A);
        check("one_last", (last_q.size() > 0) ? {31'd0, last_q[0]} : 32'hDEAD, 1);
        tick();

        // Start while busy, then reset during the second byte
        set_ptr(16'h8244);
        clear_mon();
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check("busy_reached_send", seen, 1);
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (beat_q.size() >= 1) seen = 1'b1;
            else tick();
        end
        check("busy_first_beat", seen, 1);
        check("busy_rd_in_second", rd, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_rd", rd, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_uploading", uploading, 0);
        check("mid_rst_done", done, 0);
        check("busy_rd_count", rd_q.size(), 4);
        check("busy_rd_addr3", (rd_q.size() == 4) ? {7'd0, rd_q[3]} : 32'hDEAD, 25'h8242);
        n = rd_q.size();
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_no_reads", rd_q.size(), n);
        check("mid_rst_no_done", done_cnt, 0);
        clear_mon();
        pulse_start();
        check("restart_rd", rd, 1);
        check("restart_addr", addr, 25'h8225);
        wait_done(200, seen);
        check("restart_done_seen", seen, 1);
        check_basic_stream("restart");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
